ram_quad_arb: RTL and testbench

RAM_QUAD_ARB -- requirements
Module: ram_quad_arb

---
 rtl/ram_quad_pkg.sv | 24 ++
 rtl/ram_quad_arb_rr_pick.sv | 83 ++++++++
 rtl/ram_quad_arb.sv | 152 +++++++++++++++
 tb/tb_ram_quad_arb.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_quad_pkg.sv
// rtl/ram_quad_pkg.sv - shared constants and types for the four-lane RAM arbiter
//
// Purpose : lane count, default read latency and the read-owner tag type used by
//           ram_quad_arb and rr_pick.
// Ports   : none (package).
// Config  : RAM_QUAD_ARB_RR_EN selects round-robin arbitration in rr_pick;
//           undefined gives fixed priority (lowest index wins).

package ram_quad_pkg;

  localparam int LANES      = 4;
  localparam int RD_LAT_DEF = 2;

  // Tags are sized for the largest supported requester count so one type
  // serves every REQ_N; the top only decodes the low $clog2(REQ_N) owner bits.
  localparam int REQ_N_MAX  = 8;
  localparam int OWN_W      = $clog2(REQ_N_MAX);

  typedef struct packed {
    logic             vld;
    logic [OWN_W-1:0] own;
  } tag_t;

endpackage

// File: rtl/ram_quad_arb_rr_pick.sv
// rtl/ram_quad_arb_rr_pick.sv - requester selection for ram_quad_arb
//
// Purpose : produces a one-hot grant from the request vector in the same cycle.
//           With RAM_QUAD_ARB_RR_EN defined, the search starts one past the last
//           granted requester (round-robin) and a last_grant register is kept;
//           otherwise the lowest requesting index wins and no state exists.
// Ports   : clk_i    - clock
//           rst_n_i  - asynchronous active-low reset
//           req_i    - per-requester request level
//           gnt_o    - one-hot grant, combinational from req_i

module rr_pick #(
  parameter int REQ_N = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [REQ_N-1:0] req_i,
  output logic [REQ_N-1:0] gnt_o
);

  localparam int IDX_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;

`ifdef RAM_QUAD_ARB_RR_EN

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] last_d;
  logic [IDX_W-1:0] cand;
  logic             hit;
  int unsigned      sum;

  // Walk the REQ_N positions starting at last_q+1, wrapping at REQ_N; the
  // first requesting position wins. i = REQ_N lands back on last_q itself,
  // so a lone repeat requester is still served.
  always_comb begin
    gnt_o  = '0;
    last_d = last_q;
    hit    = 1'b0;
    cand   = '0;
    sum    = 0;
    for (int i = 1; i <= REQ_N; i++) begin
      sum  = int'(last_q) + i;
      cand = IDX_W'((sum >= REQ_N) ? sum - REQ_N : sum);
      if (!hit && req_i[cand]) begin
        hit         = 1'b1;
        gnt_o[cand] = 1'b1;
        last_d      = cand;
      end
    end
  end

  // Pointer moves only when something was granted, so idle cycles and
  // requests withdrawn before service leave the rotation untouched.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_q <= IDX_W'(REQ_N - 1);
    end else if (hit) begin
      last_q <= last_d;
    end
  end

`else

  logic hit;

  always_comb begin
    gnt_o = '0;
    hit   = 1'b0;
    for (int i = 0; i < REQ_N; i++) begin
      if (!hit && req_i[i]) begin
        hit      = 1'b1;
        gnt_o[i] = 1'b1;
      end
    end
  end

  // Fixed priority is stateless; clock and reset stay on the port list so
  // both builds share one instantiation.
  logic unused_clk_rst;
  assign unused_clk_rst = clk_i ^ rst_n_i;

`endif

endmodule

// File: rtl/ram_quad_arb.sv
// rtl/ram_quad_arb.sv - N-requester arbiter onto one four-lane RAM port
//
// Purpose : grants one requester per cycle, steers its address / write enables /
//           write data onto the four RAM lanes, and tracks read ownership through
//           an RD_LAT-deep tag pipeline so returning data is flagged to its owner.
// Config  : RAM_QUAD_ARB_RR_EN defined -> round-robin, else fixed priority.
// Ports   : clk_i, rst_n_i       - clock, asynchronous active-low reset
//           req_i / gnt_o        - request levels / one-hot combinational grant
//           addr_i, wr_i, be_i,
//           wdata_i              - packed per-requester access fields
//           rdata_o / rvld_o     - shared read word / one-hot owner of that word
//           ram_addr_o, ram_wr_o,
//           ram_wdata_o          - per-lane RAM port drive
//           ram_rdata_i          - per-lane RAM read data

module ram_quad_arb
  import ram_quad_pkg::*;
#(
  parameter int REQ_N  = 4,
  parameter int ADDR_W = 13,
  parameter int LANE_W = 8,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [REQ_N-1:0]              req_i,
  output logic [REQ_N-1:0]              gnt_o,
  input  logic [REQ_N*ADDR_W-1:0]       addr_i,
  input  logic [REQ_N-1:0]              wr_i,
  input  logic [REQ_N*LANES-1:0]        be_i,
  input  logic [REQ_N*LANES*LANE_W-1:0] wdata_i,
  output logic [LANES*LANE_W-1:0]       rdata_o,
  output logic [REQ_N-1:0]              rvld_o,
  output logic [ADDR_W-1:0]             ram_addr_o  [LANES],
  output logic [LANES-1:0]              ram_wr_o,
  output logic [LANE_W-1:0]             ram_wdata_o [LANES],
  input  logic [LANE_W-1:0]             ram_rdata_i [LANES]
);

  localparam int IDX_W  = (REQ_N > 1) ? $clog2(REQ_N) : 1;
  localparam int WORD_W = LANES * LANE_W;

  // Unpack the flat requester buses once so the grant mux is a plain index.
  logic [ADDR_W-1:0] addr_arr  [REQ_N];
  logic [LANES-1:0]  be_arr    [REQ_N];
  logic [WORD_W-1:0] wdata_arr [REQ_N];

  for (genvar k = 0; k < REQ_N; k++) begin : g_unpack
    assign addr_arr[k]  = addr_i[k*ADDR_W +: ADDR_W];
    assign be_arr[k]    = be_i[k*LANES +: LANES];
    assign wdata_arr[k] = wdata_i[k*WORD_W +: WORD_W];
  end

  // Selection
  logic [REQ_N-1:0] pick_gnt;

  rr_pick #(
    .REQ_N (REQ_N)
  ) u_rr_pick (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .req_i   (req_i),
    .gnt_o   (pick_gnt)
  );

  // The grant path is combinational from req_i, so it must be forced quiet
  // while reset is asserted rather than relying on registered state.
  assign gnt_o = rst_n_i ? pick_gnt : '0;

  logic             gnt_any;
  logic [IDX_W-1:0] gnt_idx;

  always_comb begin
    gnt_any = |gnt_o;
    gnt_idx = '0;
    for (int i = 0; i < REQ_N; i++) begin
      if (gnt_o[i]) begin
        gnt_idx = IDX_W'(i);
      end
    end
  end

  // RAM port drive
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [LANES-1:0]  sel_be;
  logic [WORD_W-1:0] sel_wdata;

  always_comb begin
    sel_wr    = wr_i[gnt_idx];
    sel_addr  = addr_arr[gnt_idx];
    sel_be    = be_arr[gnt_idx];
    sel_wdata = wdata_arr[gnt_idx];
    for (int n = 0; n < LANES; n++) begin
      ram_addr_o[n]  = gnt_any ? sel_addr : '0;
      // A write with all byte enables low still takes the grant slot but
      // leaves every lane's write enable low.
      ram_wr_o[n]    = gnt_any & sel_wr & sel_be[n];
      ram_wdata_o[n] = sel_wdata[n*LANE_W +: LANE_W];
    end
  end

  // Read data is a straight lane concatenation; rvld_o says who owns it.
  always_comb begin
    rdata_o = '0;
    for (int n = 0; n < LANES; n++) begin
      rdata_o[n*LANE_W +: LANE_W] = ram_rdata_i[n];
    end
  end

  // Owner tags: one stage per clock of RAM latency. Write and idle slots enter
  // with vld = 0 so they never raise rvld_o at the far end.
  tag_t tag_in;
  tag_t tag_q [RD_LAT];

  always_comb begin
    tag_in     = '0;
    tag_in.vld = gnt_any & ~sel_wr;
    tag_in.own = OWN_W'(gnt_idx);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < RD_LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0] <= tag_in;
      for (int s = 1; s < RD_LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  tag_t             tag_out;
  logic [IDX_W-1:0] own_idx;

  assign tag_out = tag_q[RD_LAT-1];
  assign own_idx = tag_out.own[IDX_W-1:0];

  always_comb begin
    rvld_o = '0;
    if (tag_out.vld) begin
      rvld_o[own_idx] = 1'b1;
    end
  end

  // Owner bits above IDX_W exist only because the tag is sized for REQ_N_MAX.
  logic unused_tag_bits;
  assign unused_tag_bits = ^tag_out;

endmodule

// File: tb/tb_ram_quad_arb.sv
// tb/tb_ram_quad_arb.sv - directed self-checking bench for ram_quad_arb

module tb_ram_quad_arb;

  localparam int REQ_N  = 4;
  localparam int ADDR_W = 13;
  localparam int LANE_W = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [REQ_N-1:0]     req;
  logic [REQ_N-1:0]     gnt;
  logic [REQ_N*13-1:0]  addr;
  logic [REQ_N-1:0]     wr;
  logic [REQ_N*4-1:0]   be;
  logic [REQ_N*32-1:0]  wdata;
  logic [31:0]          rdata;
  logic [REQ_N-1:0]     rvld;
  logic [ADDR_W-1:0]    ram_addr  [4];
  logic [3:0]           ram_wr;
  logic [LANE_W-1:0]    ram_wdata [4];
  logic [LANE_W-1:0]    ram_rdata [4];

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  ram_quad_arb #(
    .REQ_N  (REQ_N),
    .ADDR_W (ADDR_W),
    .LANE_W (LANE_W),
    .RD_LAT (2)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_i       (req),
    .gnt_o       (gnt),
    .addr_i      (addr),
    .wr_i        (wr),
    .be_i        (be),
    .wdata_i     (wdata),
    .rdata_o     (rdata),
    .rvld_o      (rvld),
    .ram_addr_o  (ram_addr),
    .ram_wr_o    (ram_wr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  // Four-lane RAM, two-clock read latency, read-before-write.
  // Preload: lane n at word a holds {a[5:0], n[1:0]} for a < 64.
  logic [7:0] mem [4][64];
  logic [7:0] rd1 [4];
  logic [7:0] rd2 [4];
  logic       mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int n = 0; n < 4; n++) begin
        for (int a = 0; a < 64; a++) begin
          mem[n][a] <= {a[5:0], n[1:0]};
        end
        rd1[n] <= '0;
        rd2[n] <= '0;
      end
      mem_init <= 1'b1;
    end else begin
      for (int n = 0; n < 4; n++) begin
        rd1[n] <= mem[n][ram_addr[n][5:0]];
        rd2[n] <= rd1[n];
        if (ram_wr[n]) begin
          mem[n][ram_addr[n][5:0]] <= ram_wdata[n];
        end
      end
    end
  end

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      ram_rdata[n] = rd2[n];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req   = '0;
    wr    = '0;
    be    = '0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic set_rd(input int k, input logic [12:0] a);
    req[k]           = 1'b1;
    wr[k]            = 1'b0;
    addr[k*13 +: 13] = a;
  endtask

  task automatic set_wr(input int k, input logic [12:0] a, input logic [3:0] b, input logic [31:0] d);
    req[k]            = 1'b1;
    wr[k]             = 1'b1;
    addr[k*13 +: 13]  = a;
    be[k*4 +: 4]      = b;
    wdata[k*32 +: 32] = d;
  endtask

  // Leaves the bench at posedge+1 of the first cycle out of reset.
  task automatic do_reset();
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [3:0] exp_g;

  initial begin
    rst_n = 1'b0;
    idle();

    // Outputs held quiet during reset even with everything requesting.
    tick();
    req = 4'b1111;
    wr  = 4'b1111;
    be  = 16'hFFFF;
    addr[12:0] = 13'h0015;
    @(negedge clk);
    check_eq("rst_gnt",   gnt,         4'b0000);
    check_eq("rst_rvld",  rvld,        4'b0000);
    check_eq("rst_ramwr", ram_wr,      4'b0000);
    check_eq("rst_addr0", ram_addr[0], 13'h0000);
    tick();
    idle();
    tick();
    rst_n = 1'b1;

    // Single read from requester 0 at 0x0010.
    set_rd(0, 13'h0010);
    @(negedge clk);
    check_eq("rd0_gnt",   gnt,         4'b0001);
    check_eq("rd0_addr0", ram_addr[0], 13'h0010);
    check_eq("rd0_addr3", ram_addr[3], 13'h0010);
    check_eq("rd0_ramwr", ram_wr,      4'b0000);
    tick();
    idle();
    @(negedge clk);
    check_eq("rd0_rvld_t1", rvld, 4'b0000);
    tick();
    @(negedge clk);
    check_eq("rd0_rvld_t2", rvld,  4'b0001);
    check_eq("rd0_rdata",   rdata, 32'h43424140);
    check_eq("idle_gnt",    gnt,   4'b0000);
    // Idle cycle must not move the rotation: last grant was 0.
    tick();
    req = 4'b1111;
`ifdef RAM_QUAD_ARB_RR_EN
    exp_g = 4'b0010;
`else
    exp_g = 4'b0001;
`endif
    @(negedge clk);
    check_eq("hold_gnt", gnt, exp_g);
    tick();
    idle();

    // All four requesting for 8 cycles.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req = 4'b1111;
`ifdef RAM_QUAD_ARB_RR_EN
      exp_g = 4'b0001 << (i % 4);
`else
      exp_g = 4'b0001;
`endif
      @(negedge clk);
      check_eq($sformatf("rr_gnt%0d", i), gnt, exp_g);
      tick();
    end
    idle();

    // Partial write from requester 2, read back, then a be=0 write.
    do_reset();
    set_wr(2, 13'h0003, 4'b0101, 32'hA5A5A5A5);
    @(negedge clk);
    check_eq("wr_gnt",    gnt,          4'b0100);
    check_eq("wr_ramwr",  ram_wr,       4'b0101);
    check_eq("wr_addr1",  ram_addr[1],  13'h0003);
    check_eq("wr_wdata2", ram_wdata[2], 8'hA5);
    tick();
    idle();
    set_rd(2, 13'h0003);
    @(negedge clk);
    check_eq("wrrd_gnt",   gnt,    4'b0100);
    check_eq("wrrd_ramwr", ram_wr, 4'b0000);
    tick();
    idle();
    set_wr(2, 13'h0010, 4'b0000, 32'hFFFFFFFF);
    @(negedge clk);
    check_eq("be0_gnt",     gnt,    4'b0100);
    check_eq("be0_ramwr",   ram_wr, 4'b0000);
    check_eq("wr_no_rvld",  rvld,   4'b0000);
    tick();
    idle();
    @(negedge clk);
    check_eq("wrrd_rvld",  rvld,  4'b0100);
    check_eq("wrrd_rdata", rdata, 32'h0FA50DA5);
    tick();
    set_rd(0, 13'h0010);
    @(negedge clk);
    check_eq("be0_no_rvld", rvld, 4'b0000);
    tick();
    idle();
    tick();
    @(negedge clk);
    check_eq("be0_rdata", rdata, 32'h43424140);
    tick();

    // Alternating back-to-back reads from requesters 1 and 3.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i < 4) begin
        if (i % 2 == 0) set_rd(1, 13'h0005);
        else            set_rd(3, 13'h000A);
      end
      @(negedge clk);
      if (i < 4) begin
        check_eq($sformatf("alt_gnt%0d", i), gnt, (i % 2 == 0) ? 4'b0010 : 4'b1000);
      end
      if (i >= 2) begin
        check_eq($sformatf("alt_rvld%0d", i), rvld,
                 ((i - 2) % 2 == 0) ? 4'b0010 : 4'b1000);
        check_eq($sformatf("alt_rdata%0d", i), rdata,
                 ((i - 2) % 2 == 0) ? 32'h17161514 : 32'h2B2A2928);
      end
      tick();
    end
    idle();

    // Reset pulse while a read is in flight.
    do_reset();
    set_rd(2, 13'h0005);
    @(negedge clk);
    check_eq("flt_gnt", gnt, 4'b0100);
    tick();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("flt_rvld_rst", rvld, 4'b0000);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("flt_rvld_t2", rvld, 4'b0000);
    tick();
    req = 4'b1111;
    @(negedge clk);
    check_eq("flt_rvld_t3", rvld, 4'b0000);
    check_eq("post_rst_gnt", gnt, 4'b0001);
    tick();
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
